// File: rtl/dot_product_accumulator.sv
// Sums K consecutive unsigned products into one saturating result. The result sits in a
// registered valid/ready output slot, and the next dot product keeps accumulating meanwhile.
module dot_product_accumulator #(
  parameter int K     = 4,
  parameter int PW    = 8,
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat,
  output logic [3:0]       out_seq
);
  localparam int CW = $clog2(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_sat;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_out_sat;
  logic [3:0]       r_out_seq;

  logic             w_last;
  logic             w_accept;
  logic             w_fire;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf;
  logic [ACC_W-1:0] w_sat_sum;

  // One spare bit catches the carry out of the add; a set carry clamps the result to all ones.
  assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(in_product);
  assign w_ovf     = w_sum[ACC_W];
  assign w_sat_sum = w_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

  assign w_last    = (r_cnt == LAST);
  assign out_valid = (r_state == HOLD);
  assign in_ready  = !(out_valid && !out_ready && w_last);
  assign w_accept  = in_valid && in_ready;
  assign w_fire    = out_valid && out_ready;

  assign out_sum   = r_out_sum;
  assign out_sat   = r_out_sat;
  assign out_seq   = r_out_seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ACCUM;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_out_sum <= '0;
      r_out_sat <= 1'b0;
      r_out_seq <= '0;
    end else if (clear) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      if (w_fire) r_state <= ACCUM;
      // A last-term accept in the same cycle as a fire reloads the slot with no bubble.
      if (w_accept) begin
        if (w_last) begin
          r_out_sum <= w_sat_sum;
          r_out_sat <= r_sat | w_ovf;
          r_out_seq <= r_out_seq + 4'd1;
          r_state   <= HOLD;
          r_acc     <= '0;
          r_cnt     <= '0;
          r_sat     <= 1'b0;
        end else begin
          r_acc <= w_sat_sum;
          r_cnt <= r_cnt + CW'(1);
          r_sat <= r_sat | w_ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_dot_product_accumulator.sv
// Drives two instances (ACC_W 10 and 9) with one shared stream and compares both against a
// reference model that tracks the running term total and an expected output slot.
module tb_dot_product_accumulator;
  localparam int K = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_product = '0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_sat;
  logic [9:0] out_sum;
  logic [3:0] out_seq;
  logic       in_ready9, out_valid9, out_sat9;
  logic [8:0] out_sum9;
  logic [3:0] out_seq9;

  dot_product_accumulator #(.K(K), .PW(8), .ACC_W(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_product(in_product), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_sat(out_sat), .out_seq(out_seq));

  dot_product_accumulator #(.K(K), .PW(8), .ACC_W(9)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready9),
    .in_product(in_product), .out_valid(out_valid9), .out_ready(out_ready),
    .out_sum(out_sum9), .out_sat(out_sat9), .out_seq(out_seq9));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: running total of accepted terms; the result is min(total, max) and the
  // saturation flag is total > max (adds of unsigned terms only ever grow).
  int m_n, m_tot, m_seq;
  bit m_v, m_sat10, m_sat9;
  int m_sum10, m_sum9;

  function automatic void model_reset();
    m_n = 0; m_tot = 0; m_seq = 0; m_v = 0;
    m_sat10 = 0; m_sat9 = 0; m_sum10 = 0; m_sum9 = 0;
  endfunction

  task automatic step(input bit v, input int p, input bit ordy, input bit clr, output bit acc);
    bit rdy, fire, done;
    in_valid = v; in_product = p[7:0]; out_ready = ordy; clear = clr;
    @(negedge clk);
    rdy = !(m_v && !ordy && m_n == K-1);
    chk("in_ready", in_ready, rdy);
    chk("in_ready9", in_ready9, rdy);
    chk("out_valid", out_valid, m_v);
    chk("out_valid9", out_valid9, m_v);
    chk("out_seq", out_seq, m_seq);
    chk("out_seq9", out_seq9, m_seq);
    if (m_v) begin
      chk("out_sum", out_sum, m_sum10);
      chk("out_sat", out_sat, m_sat10);
      chk("out_sum9", out_sum9, m_sum9);
      chk("out_sat9", out_sat9, m_sat9);
    end
    acc  = v && rdy && !clr;
    fire = m_v && ordy;
    @(posedge clk);
    if (clr) begin
      m_n = 0; m_tot = 0; m_v = 0;
    end else begin
      done = 0;
      if (acc) begin
        m_tot += p;
        if (m_n == K-1) begin
          m_sum10 = (m_tot > 1023) ? 1023 : m_tot; m_sat10 = (m_tot > 1023);
          m_sum9  = (m_tot > 511)  ? 511  : m_tot; m_sat9  = (m_tot > 511);
          m_seq = (m_seq + 1) % 16;
          m_n = 0; m_tot = 0; m_v = 1; done = 1;
        end else m_n++;
      end
      if (fire && !done) m_v = 0;
    end
    #1;
    in_valid = 0; clear = 0;
  endtask

  task automatic send(input int p, input bit ordy);
    bit acc;
    for (int t = 0; t < 20; t++) begin
      step(1'b1, p, ordy, 1'b0, acc);
      if (acc) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  // Async reset pulse in mid-cycle; outputs must drop before any clock edge.
  task automatic pulse_reset();
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_seq", out_seq, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid9", out_valid9, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    model_reset();
    #3;
    chk("init_valid", out_valid, 0);
    chk("init_sum", out_sum, 0);
    chk("init_seq", out_seq, 0);
    chk("init_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // basic
    send(10, 1); send(20, 1); send(30, 1); send(40, 1);
    chk("basic_sum", out_sum, 100);
    chk("basic_sat", out_sat, 0);
    chk("basic_seq", out_seq, 1);
    step(0, 0, 1, 0, acc);
    chk("basic_one_cycle", out_valid, 0);

    // back-to-back
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 225, 1, 0, acc);
      chk("b2b_accept", acc, 1);
      if (i == 3) begin chk("b2b_sum1", out_sum, 900); chk("b2b_seq1", out_seq, 1); end
      if (i == 7) begin chk("b2b_sum2", out_sum, 900); chk("b2b_seq2", out_seq, 2); end
    end
    step(0, 0, 1, 0, acc);

    // saturation and sticky flag clearing
    pulse_reset();
    for (int i = 0; i < 4; i++) send(225, 1);
    chk("sat_sum9", out_sum9, 511);
    chk("sat_flag9", out_sat9, 1);
    chk("sat_sum10", out_sum, 900);
    chk("sat_flag10", out_sat, 0);
    for (int i = 0; i < 4; i++) send(1, 1);
    chk("sat_clr_sum9", out_sum9, 4);
    chk("sat_clr_flag9", out_sat9, 0);
    step(0, 0, 1, 0, acc);

    // backpressure
    pulse_reset();
    for (int i = 0; i < 7; i++) send(1, 0);
    step(1, 1, 0, 0, acc);
    chk("bp_stall", acc, 0);
    chk("bp_held_sum", out_sum, 4);
    step(1, 1, 1, 0, acc);
    chk("bp_release_accept", acc, 1);
    chk("bp_sum2", out_sum, 4);
    chk("bp_seq2", out_seq, 2);
    chk("bp_valid2", out_valid, 1);
    step(0, 0, 1, 0, acc);

    // clear drops the partial sum and the term presented with it
    pulse_reset();
    send(50, 1); send(50, 1);
    step(1, 50, 1, 1, acc);
    chk("clr_ready_after", in_ready, 1);
    for (int i = 0; i < 4; i++) send(5, 1);
    chk("clr_sum", out_sum, 20);
    chk("clr_seq", out_seq, 1);
    step(0, 0, 1, 0, acc);

    // reset mid-accumulation while a result is held
    for (int i = 0; i < 5; i++) send(3, 0);
    chk("rstmid_valid_pre", out_valid, 1);
    pulse_reset();
    for (int i = 0; i < 4; i++) send(2, 1);
    chk("rstmid_sum", out_sum, 8);
    chk("rstmid_seq", out_seq, 1);

    // randomized
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) == 0, acc);
    end
    step(0, 0, 1, 0, acc);
    step(0, 0, 1, 0, acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
